accel_hash_ctrl: RTL and testbench

Sequencing controller for the SHA-256 compression datapath. It accepts one 512-bit message block per valid/ready handshake and expands the message schedule W[0..63] in a 16-word sliding window. It drives the compressor's `rst_hash_n`, `update_A_H`, `is_hashing`, `i`, `w` and `update_H0_7` controls through init, load, 64 rounds and accumulate, then flags the 256-bit digest on `cm_out` as valid. Multi-block messages chain by clearing `blk_first` on later blocks.

---
 rtl/accel_hash_ctrl_if.sv | 10 +
 rtl/accel_hash_ctrl.sv | 89 ++++++++
 tb/tb_accel_hash_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/accel_hash_ctrl_if.sv
// rtl/accel_hash_ctrl_if.sv - block handshake bundle between message source and hash controller
interface accel_hash_ctrl_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;

  modport master (output blk_valid, output blk_data, output blk_first, input blk_ready);
  modport slave  (input blk_valid, input blk_data, input blk_first, output blk_ready);
endinterface

// File: rtl/accel_hash_ctrl.sv
// rtl/accel_hash_ctrl.sv - SHA-256 compression sequencer with 16-word message schedule window
module accel_hash_ctrl (
  input  logic                clk,
  input  logic                rst_n,
  accel_hash_ctrl_if.slave    blk,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                digest_valid,
  output logic                rst_hash_n,
  output logic                update_A_H,
  output logic                is_hashing,
  output logic                update_H0_7,
  output logic [6:0]          i,
  output logic [31:0]         w
);

  typedef enum logic [2:0] {IDLE, INIT, LOAD, ROUND, UPDATE, DONE} state_t;

  state_t      state, state_next;
  logic [6:0]  cnt;
  logic [31:0] win [16];
  logic [31:0] next_w;
  logic        accept;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // abort wins over a simultaneous offer, so the block is simply never taken
  assign accept = (state == IDLE) && blk.blk_valid && !abort;
  assign next_w = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = blk.blk_first ? INIT : LOAD;
      INIT:    state_next = LOAD;
      LOAD:    state_next = ROUND;
      ROUND:   if (cnt == 7'd63) state_next = UPDATE;
      UPDATE:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && state != IDLE) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= 7'd0;
      digest_valid <= 1'b0;
      for (int j = 0; j < 16; j++) win[j] <= 32'd0;
    end else begin
      if (accept) begin
        for (int j = 0; j < 16; j++) win[j] <= blk.blk_data[511 - 32*j -: 32];
      end else if (state == ROUND) begin
        for (int j = 0; j < 15; j++) win[j] <= win[j+1];
        win[15] <= next_w;
      end

      // counter parks at 0 after round 63 rather than running into a 65th round
      if (state == LOAD)       cnt <= 7'd0;
      else if (state == ROUND) cnt <= (cnt == 7'd63) ? 7'd0 : cnt + 7'd1;

      if (accept || abort)          digest_valid <= 1'b0;
      else if (state_next == DONE)  digest_valid <= 1'b1;
    end
  end

  assign blk.blk_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign rst_hash_n    = (state != INIT);
  assign update_A_H    = (state == LOAD);
  assign is_hashing    = (state == ROUND);
  assign update_H0_7   = (state == UPDATE);
  assign i             = (state == ROUND) ? cnt : 7'd0;
  assign w             = (state == ROUND) ? win[0] : 32'd0;

endmodule

// File: tb/tb_accel_hash_ctrl.sv
// tb/tb_accel_hash_ctrl.sv - directed bench with a behavioural SHA-256 compressor on the control outputs
module tb_accel_hash_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic        busy, done, digest_valid, rst_hash_n, update_A_H, is_hashing, update_H0_7;
  logic [6:0]  idx;
  logic [31:0] wd;
  logic [255:0] cm_out;
  int checks = 0;
  int errors = 0;

  accel_hash_ctrl_if bif();

  accel_hash_ctrl dut (
    .clk(clk), .rst_n(rst_n), .blk(bif.slave), .abort(abort),
    .busy(busy), .done(done), .digest_valid(digest_valid),
    .rst_hash_n(rst_hash_n), .update_A_H(update_A_H), .is_hashing(is_hashing),
    .update_H0_7(update_H0_7), .i(idx), .w(wd)
  );

  always #5 clk = ~clk;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_L1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_L2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_LONG  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  logic [31:0] iv [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] hh [8];
  logic [31:0] st [8];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] f_t1(input logic [31:0] e, f, g, h, k, x);
    return h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + x;
  endfunction
  function automatic logic [31:0] f_t2(input logic [31:0] a, b, c);
    return (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
  endfunction

  // compressor driven purely by the controller's control outputs
  always @(posedge clk) begin
    if (!rst_hash_n) for (int j = 0; j < 8; j++) hh[j] <= iv[j];
    if (update_A_H)  for (int j = 0; j < 8; j++) st[j] <= hh[j];
    if (is_hashing) begin
      st[0] <= f_t1(st[4], st[5], st[6], st[7], k_tab[idx[5:0]], wd) + f_t2(st[0], st[1], st[2]);
      st[1] <= st[0]; st[2] <= st[1]; st[3] <= st[2];
      st[4] <= st[3] + f_t1(st[4], st[5], st[6], st[7], k_tab[idx[5:0]], wd);
      st[5] <= st[4]; st[6] <= st[5]; st[7] <= st[6];
    end
    if (update_H0_7) for (int j = 0; j < 8; j++) hh[j] <= hh[j] + st[j];
  end
  assign cm_out = {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};

  task automatic run_block(input logic [511:0] data, input logic first, output int done_cyc,
                           output logic [31:0] w16, output logic [31:0] w17,
                           output int excl_err, output logic dv1);
    @(negedge clk);
    bif.blk_data = data; bif.blk_first = first; bif.blk_valid = 1'b1;
    @(posedge clk); #1 bif.blk_valid = 1'b0;
    done_cyc = -1; excl_err = 0; w16 = '0; w17 = '0; dv1 = 1'bx;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (int'(!rst_hash_n) + int'(update_A_H) + int'(is_hashing) + int'(update_H0_7) > 1) excl_err++;
      if (c == 1) dv1 = digest_valid;
      if (is_hashing && idx == 7'd16) w16 = wd;
      if (is_hashing && idx == 7'd17) w17 = wd;
      if (done) begin done_cyc = c; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; abort = 1'b0; bif.blk_valid = 1'b0; bif.blk_first = 1'b0; bif.blk_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bif.blk_ready, busy, done, digest_valid, rst_hash_n, update_A_H, is_hashing, update_H0_7, idx, wd}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0}) begin
      errors++; $display("FAIL reset_outputs: got ready=%b busy=%b done=%b dv=%b rhn=%b uah=%b ish=%b uh=%b i=%0d w=%h",
                         bif.blk_ready, busy, done, digest_valid, rst_hash_n, update_A_H, is_hashing, update_H0_7, idx, wd);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_abc();
    int dc, ex; logic [31:0] a16, a17; logic dv1;
    run_block(BLK_ABC, 1'b1, dc, a16, a17, ex, dv1);
    checks++; if (dc !== 68) begin errors++; $display("FAIL abc_done_cycle: got %0d expected 68", dc); end
    checks++; if (cm_out !== DIG_ABC) begin errors++; $display("FAIL abc_digest: got %h expected %h", cm_out, DIG_ABC); end
    checks++; if (digest_valid !== 1'b1) begin errors++; $display("FAIL abc_digest_valid: got %b expected 1", digest_valid); end
    checks++; if (a16 !== 32'h61626380) begin errors++; $display("FAIL abc_w16: got %h expected 61626380", a16); end
    checks++; if (a17 !== 32'h000f0000) begin errors++; $display("FAIL abc_w17: got %h expected 000f0000", a17); end
    checks++; if (ex !== 0) begin errors++; $display("FAIL abc_exclusive: got %0d overlaps expected 0", ex); end
    @(negedge clk);
    checks++; if (bif.blk_ready !== 1'b1) begin errors++; $display("FAIL abc_ready_c69: got %b expected 1", bif.blk_ready); end
  endtask

  task automatic test_empty();
    int dc, ex; logic [31:0] a16, a17; logic dv1;
    run_block(BLK_EMPTY, 1'b1, dc, a16, a17, ex, dv1);
    checks++; if (dv1 !== 1'b0) begin errors++; $display("FAIL empty_dv_cleared_on_accept: got %b expected 0", dv1); end
    checks++; if (cm_out !== DIG_EMPTY) begin errors++; $display("FAIL empty_digest: got %h expected %h", cm_out, DIG_EMPTY); end
  endtask

  task automatic test_two_block();
    int dc, ex; logic [31:0] a16, a17; logic dv1;
    run_block(BLK_L1, 1'b1, dc, a16, a17, ex, dv1);
    checks++; if (dc !== 68) begin errors++; $display("FAIL long_first_done_cycle: got %0d expected 68", dc); end
    run_block(BLK_L2, 1'b0, dc, a16, a17, ex, dv1);
    checks++; if (dc !== 67) begin errors++; $display("FAIL long_chained_done_cycle: got %0d expected 67", dc); end
    checks++; if (ex !== 0) begin errors++; $display("FAIL long_exclusive: got %0d overlaps expected 0", ex); end
    checks++; if (cm_out !== DIG_LONG) begin errors++; $display("FAIL long_digest: got %h expected %h", cm_out, DIG_LONG); end
  endtask

  task automatic test_back_to_back();
    int accepts = 0, acc_cyc = -1, dones = 0, d1 = -1, d2 = -1;
    @(negedge clk);
    bif.blk_data = BLK_ABC; bif.blk_first = 1'b1; bif.blk_valid = 1'b1;
    for (int c = 1; c <= 137; c++) begin
      @(negedge clk);
      if (bif.blk_ready) begin accepts++; acc_cyc = c; end
      if (done) begin dones++; if (dones == 1) d1 = c; else d2 = c; end
    end
    bif.blk_valid = 1'b0;
    checks++; if (accepts !== 1 || acc_cyc !== 69) begin errors++; $display("FAIL b2b_accept: got %0d accepts at cycle %0d expected 1 at 69", accepts, acc_cyc); end
    checks++; if (d1 !== 68 || d2 !== 137) begin errors++; $display("FAIL b2b_done_cycles: got %0d,%0d expected 68,137", d1, d2); end
    checks++; if (cm_out !== DIG_ABC) begin errors++; $display("FAIL b2b_digest: got %h expected %h", cm_out, DIG_ABC); end
  endtask

  task automatic test_abort_idle();
    @(negedge clk);
    checks++; if (digest_valid !== 1'b1) begin errors++; $display("FAIL idle_dv_held: got %b expected 1", digest_valid); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (digest_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_abort: got dv=%b busy=%b expected 0,0", digest_valid, busy); end
    bif.blk_data = BLK_ABC; bif.blk_first = 1'b1; bif.blk_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    bif.blk_valid = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_on_accept: got busy=%b expected 0", busy); end
  endtask

  task automatic test_abort_round();
    int seen = 0, bad = 0, dc, ex; logic [31:0] a16, a17; logic dv1;
    @(negedge clk);
    bif.blk_data = BLK_EMPTY; bif.blk_first = 1'b1; bif.blk_valid = 1'b1;
    @(posedge clk); #1 bif.blk_valid = 1'b0;
    for (int c = 1; c <= 100 && seen == 0; c++) begin
      @(negedge clk);
      if (update_H0_7 || done) bad++;
      if (is_hashing && idx == 7'd30) seen = 1;
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL abort_reach_i30: got %0d expected 1", seen); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || digest_valid !== 1'b0) begin errors++; $display("FAIL abort_round_state: got busy=%b dv=%b expected 0,0", busy, digest_valid); end
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (update_H0_7 || done || busy) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort_no_update: got %0d stray cycles expected 0", bad); end
    run_block(BLK_ABC, 1'b1, dc, a16, a17, ex, dv1);
    checks++; if (dc !== 68 || cm_out !== DIG_ABC) begin errors++; $display("FAIL abort_then_abc: got cycle %0d digest %h expected 68 %h", dc, cm_out, DIG_ABC); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    bif.blk_data = BLK_ABC; bif.blk_first = 1'b1; bif.blk_valid = 1'b1;
    @(posedge clk); #1 bif.blk_valid = 1'b0;
    for (int c = 1; c <= 100 && seen == 0; c++) begin
      @(negedge clk);
      if (is_hashing && idx == 7'd40) seen = 1;
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL reset_reach_i40: got %0d expected 1", seen); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bif.blk_ready, busy, done, digest_valid, rst_hash_n, update_A_H, is_hashing, update_H0_7, idx, wd}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0}) begin
      errors++; $display("FAIL reset_mid_outputs: got busy=%b dv=%b rhn=%b ish=%b i=%0d w=%h",
                         busy, digest_valid, rst_hash_n, is_hashing, idx, wd);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_two_block();
    test_back_to_back();
    test_abort_idle();
    test_abort_round();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
